// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   typedef logic [7:0] byte_t;

   localparam int unsigned DEF_MAX_BURST    = 16;
   localparam int unsigned DEF_IDLE_TIMEOUT = 255;

   // Counter width able to hold the value max_val itself.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               found
);

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[wrap_add(ptr, i)]) begin
            pick[wrap_add(ptr, i)] = 1'b1;
            found                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX serializer among
// NUM_REQ byte streams, with a burst cap and an idle timeout on each grant.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int BURST_W = cnt_w(MAX_BURST);
   localparam int IDLE_W  = cnt_w(IDLE_TIMEOUT);

   arb_state_t           state;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     g_idx;
   logic [NUM_REQ-1:0]   grant_p1;
   logic [BURST_W-1:0]   burst_cnt;
   logic [IDLE_W-1:0]    idle_cnt;
   logic                 vld_p1;
   byte_t                data_p1;

   byte_t                req_bytes [NUM_REQ];
   logic [NUM_REQ-1:0]   pick;
   logic                 found;
   logic [PTR_W-1:0]     pick_idx;
   logic [PTR_W-1:0]     ptr_next;
   logic                 slot_open;
   logic                 accept;
   logic                 release_now;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data_i[8*gi +: 8];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req   (req_valid_i),
      .ptr   (ptr),
      .pick  (pick),
      .found (found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = PTR_W'(i);
      end
   end

   assign ptr_next = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

   // The one-deep buffer can take a byte when empty or draining this cycle.
   assign slot_open   = !vld_p1 || tx_ready_i;
   assign req_ready_o = grant_p1 & {NUM_REQ{slot_open}};
   assign accept      = |(req_valid_i & req_ready_o);

   assign release_now = (accept && (req_last_i[g_idx] || burst_cnt == BURST_W'(MAX_BURST - 1)))
                     || (!req_valid_i[g_idx] && idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         g_idx     <= '0;
         grant_p1  <= '0;
         burst_cnt <= '0;
         idle_cnt  <= '0;
         vld_p1    <= 1'b0;
         data_p1   <= '0;
      end else begin
         if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= req_bytes[g_idx];
         end else if (tx_ready_i) begin
            vld_p1  <= 1'b0;
         end

         case (state)
            ARB_IDLE: begin
               if (found) begin
                  state     <= ARB_GRANT;
                  grant_p1  <= pick;
                  g_idx     <= pick_idx;
                  ptr       <= ptr_next;
                  burst_cnt <= '0;
                  idle_cnt  <= '0;
               end
            end
            ARB_GRANT: begin
               if (accept) burst_cnt <= burst_cnt + 1'b1;
               if (req_valid_i[g_idx]) idle_cnt <= '0;
               else                    idle_cnt <= idle_cnt + 1'b1;
               if (release_now) begin
                  state    <= ARB_IDLE;
                  grant_p1 <= '0;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign grant_o    = grant_p1;
   assign tx_valid_o = vld_p1;
   assign tx_data_o  = data_p1;
   assign busy_o     = (state == ARB_GRANT) || vld_p1;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the SoC's single UART transmitter between several byte-stream requesters, such as the CPU console, a boot monitor and a debug/status source. It sits between the requesters and the existing UART TX serializer, which it drives through a valid/ready byte interface. Arbitration is round-robin at packet granularity, so bytes from different requesters never interleave within a packet. Two limits release a grant to prevent starvation: a burst cap and an idle timeout.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `MAX_BURST`, default 16: maximum bytes accepted per grant.
- `IDLE_TIMEOUT`, default 255: consecutive granted cycles with `req_valid_i` low that cause the grant to be released.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester byte valid.
- `req_data_i`  in  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k].
- `req_last_i`  in  NUM_REQ  marks the final byte of a packet.
- `req_ready_o`  out  NUM_REQ  per-requester byte accepted.
- `tx_valid_o`  out  1  byte available to the serializer.
- `tx_data_o`  out  8  byte to the serializer.
- `tx_ready_i`  in  1  serializer accepts the byte.
- `grant_o`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy_o`  out  1  asserted when in GRANT or when `tx_valid_o` is high.

## Operation
- The FSM has two states, IDLE and GRANT. Reset forces IDLE, round-robin pointer = 0, burst count = 0, idle count = 0, output buffer empty.
- IDLE:
  - If any `req_valid_i` bit is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register the pick into `grant_o` and move to GRANT.
  - The pointer becomes pick+1 mod NUM_REQ.
- GRANT:
  - `req_ready_o[g] = !tx_valid_o || tx_ready_i`. All other ready bits are 0.
  - An accept (valid && ready) loads `tx_data_o`, sets `tx_valid_o` and increments the burst count.
- Release (return to IDLE next cycle, `grant_o` cleared) occurs on the first of:
  - accepting a byte with `req_last_i` high;
  - accepting the MAX_BURST-th byte;
  - the idle count reaching IDLE_TIMEOUT.
- Burst count and idle count clear on every entry to GRANT. The idle count clears on any cycle where `req_valid_i[g]` is high.
- Output buffer:
  - It is one entry deep and drains independently of the FSM.
  - `tx_valid_o` clears on `tx_ready_i` unless a new byte loads in the same cycle. A simultaneous drain and load keeps `tx_valid_o` high with the new data.
- A requester whose packet was cut by the burst cap or the timeout competes again normally. Packet continuity is not guaranteed past MAX_BURST bytes.
- Requests that arrive while another requester is granted wait; they are never dropped.
- `req_ready_o` never rises unless `grant_o` for the same requester is already high.

## Timing
- Reset values: `req_ready_o` = 0, `tx_valid_o` = 0, `tx_data_o` = 8'h00, `grant_o` = 0, `busy_o` = 0.
- Grant latency: valid seen in IDLE at cycle N, then `grant_o` and `req_ready_o` high at cycle N+1 (if the buffer is empty or draining).
- Data latency: a byte accepted at cycle N appears on `tx_valid_o`/`tx_data_o` at cycle N+1.
- Throughput: one byte per cycle while `tx_ready_i` is held high.
- There is exactly one bubble cycle in IDLE between consecutive grants, including a regrant to the same requester.
- Reset asserted mid-packet or mid-drain discards the buffered byte immediately. All outputs take their reset values on the following edge.

## Structure
- A shared package `uart_arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_GRANT`);
  - a `byte_t` typedef;
  - width helper constants derived from `$clog2` of `MAX_BURST`/`IDLE_TIMEOUT`.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot pick and found flag.
- The top level holds the FSM, counters and output buffer.

## Test plan
- Single packet: requester 0 sends 8'h41, 8'h42 (last) with `tx_ready_i` = 1. Expected: `grant_o` = 01 one cycle after valid; `tx_data_o` shows 41 then 42 on consecutive cycles; IDLE after 42; `busy_o` low once the buffer drains.
- Contention: both requesters hold 3-byte packets from reset. Expected: requester 0 is served first, then after one bubble cycle requester 1; no interleaving; the pointer then favours requester 0.
- Backpressure: `tx_ready_i` low for 5 cycles during a packet. Expected: `req_ready_o` low, `tx_data_o` stable, no byte lost or duplicated.
- Burst cap: with MAX_BURST = 4, requester 1 streams 10 bytes without last while requester 0 waits. Expected: requester 1's grant is released after 4 accepts and requester 0 is granted next.
- Timeout: with IDLE_TIMEOUT = 8, requester 0 is granted then drops valid. Expected: the grant releases after 8 idle cycles and a pending requester 1 is then granted.
- Reset mid-packet: `reset_i` is asserted with `tx_valid_o` high. Expected: the next cycle shows all outputs zero and the FSM in IDLE.
